punt_cycle_sequencer: RTL
=========================

PUNT_CYCLE_SEQUENCER -- requirements
Module: punt_cycle_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 200: the number of WAIT-state cycles before a forced termination; legal range is 2..255.
REQ-002 SHALL have port CLKCPU_A, input, 1 bit: the CPU clock; it is the only clock.
REQ-003 SHALL have port RESET_N, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port AS20, input, 1 bit: CPU address strobe, active-low.
REQ-005 SHALL have port DS20, input, 1 bit: CPU data strobe, active-low.
REQ-006 SHALL have port PUNT_IN, input, 1 bit: 1 means the accelerator is not punting this cycle.
REQ-007 SHALL have port ENABLE, input, 1 bit: 1 means port override is enabled.
REQ-008 SHALL have port HIT, input, 4 bits: decoded address-class hits; bit0 has the highest priority.
REQ-009 SHALL have port MCU_RDY, input, 1 bit: STM32 ready; asynchronous to CLKCPU_A.
REQ-010 SHALL have port INT_REQ, output, 4 bits: one-hot service request to the STM32.
REQ-011 SHALL have port DSACK, output, 2 bits: DSACK value; meaningful only while DSACK_OE=1.
REQ-012 SHALL have port DSACK_OE, output, 1 bit: 1 means DSACK is driven; the top level tristates DSACK otherwise.
REQ-013 SHALL have port PUNT_DRV, output, 1 bit: 1 means the top level drives PUNT_OUT low.
REQ-014 SHALL have port BUSY, output, 1 bit: 1 whenever the state is not IDLE.
REQ-015 SHALL have port TIMEOUT, output, 1 bit: one-cycle pulse when a forced termination occurs.

Function
REQ-016 SHALL implement four states: IDLE, WAIT, ACK and RELEASE.
REQ-017 SHALL pass MCU_RDY through a two-flop synchroniser plus a history flop; a rising edge (rdy_edge) is synchronised = 1 while history = 0.
REQ-018 SHALL ignore rdy_edge in every state except WAIT.
REQ-019 SHALL make PUNT_DRV combinational, equal to PUNT_IN & ENABLE & (HIT != 0), independent of state.
REQ-020 SHALL, in IDLE, when sampling AS20=0, DS20=0, PUNT_IN=1, ENABLE=1 and HIT != 0:
- latch grant as the index of the lowest set bit of HIT;
- clear the 8-bit counter;
- go to WAIT on the next edge.
REQ-021 SHALL hold grant constant from entry to WAIT until the return to IDLE; HIT changes in that interval are ignored.
REQ-022 SHALL, in WAIT, drive INT_REQ[grant]=1 with all other INT_REQ bits 0, drive DSACK_OE=1 and DSACK=2'b11, and increment the counter each cycle.
REQ-023 SHALL, in WAIT, go to ACK on rdy_edge.
REQ-024 SHALL, in WAIT with no rdy_edge and counter = TIMEOUT_CYCLES-1, go to ACK and pulse TIMEOUT=1 for exactly that cycle.
REQ-025 SHALL, when rdy_edge and the timeout condition occur in the same cycle, treat the event as a normal ACK with TIMEOUT=0.
REQ-026 SHALL, in WAIT with AS20=1 (cycle aborted), return to IDLE with DSACK_OE=0 on the next cycle; AS20=1 takes precedence over rdy_edge and timeout.
REQ-027 SHALL, in ACK, drive DSACK=2'b10 (8-bit port ack), DSACK_OE=1 and INT_REQ=0, and hold until AS20=1, then go to RELEASE.
REQ-028 SHALL, in RELEASE, drive DSACK=2'b11 and DSACK_OE=1 for exactly one cycle, then go to IDLE with DSACK_OE=0.
REQ-029 SHALL NOT start a new cycle from RELEASE; a back-to-back request is accepted only in IDLE.
REQ-030 SHALL keep the counter 8 bits wide and saturating; it SHALL NOT wrap.
REQ-031 SHALL keep INT_REQ one-hot or zero at all times.

Reset
REQ-032 SHALL, while RESET_N=0 at a clock edge, set state=IDLE, INT_REQ=0, DSACK=2'b11, DSACK_OE=0, BUSY=0, TIMEOUT=0, counter=0, grant=0, and all synchroniser and history flops to 0.
REQ-033 SHALL, when reset is asserted mid-cycle in any state, release DSACK_OE and INT_REQ on that same edge; PUNT_DRV is unaffected because it is combinational.

Verification
REQ-034 Normal cycle: HIT=4'b0100, strobes low, PUNT_IN=1, ENABLE=1; MCU_RDY rises 10 cycles later -> INT_REQ=4'b0100 while waiting; DSACK=2'b10 within 4 cycles of the edge; DSACK_OE drops 2 cycles after AS20 rises.
REQ-035 Priority: HIT=4'b1010 -> INT_REQ=4'b0010; changing HIT to 4'b1000 during WAIT leaves INT_REQ=4'b0010.
REQ-036 Timeout: TIMEOUT_CYCLES=20 and MCU_RDY held low -> TIMEOUT pulses once after 20 WAIT cycles, then DSACK=2'b10.
REQ-037 Abort and stale edge: AS20 rises in WAIT cycle 5 -> IDLE with DSACK_OE=0; an MCU_RDY edge while in IDLE does not complete the next cycle.
REQ-038 Gating and reset: PUNT_IN=0 or ENABLE=0 with a hit -> PUNT_DRV=0 and the block stays IDLE; RESET_N=0 in ACK -> DSACK_OE=0 and INT_REQ=0 on that edge.

Source files
------------

// File: rtl/punt_cycle_sequencer.sv
// rtl/punt_cycle_sequencer.sv - punted CPU cycle sequencer handing service to the STM32 and returning an 8-bit DSACK
module punt_cycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 200
) (
  input  logic       CLKCPU_A,
  input  logic       RESET_N,
  input  logic       AS20,
  input  logic       DS20,
  input  logic       PUNT_IN,
  input  logic       ENABLE,
  input  logic [3:0] HIT,
  input  logic       MCU_RDY,
  output logic [3:0] INT_REQ,
  output logic [1:0] DSACK,
  output logic       DSACK_OE,
  output logic       PUNT_DRV,
  output logic       BUSY,
  output logic       TIMEOUT
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state;
  state_t     state_nxt;
  logic [7:0] count;
  logic [1:0] grant;
  logic [1:0] hit_index;
  logic       rdy_sync1;
  logic       rdy_sync2;
  logic       rdy_hist;
  logic       rdy_edge;
  logic       start;

  assign rdy_edge = rdy_sync2 & ~rdy_hist;
  assign PUNT_DRV = PUNT_IN & ENABLE & (HIT != 4'b0000);
  assign BUSY     = (state != IDLE);

  always_comb begin
    hit_index = 2'd3;
    if (HIT[0])      hit_index = 2'd0;
    else if (HIT[1]) hit_index = 2'd1;
    else if (HIT[2]) hit_index = 2'd2;
  end

  always_ff @(posedge CLKCPU_A) begin
    if (!RESET_N) begin
      state     <= IDLE;
      count     <= 8'd0;
      grant     <= 2'd0;
      rdy_sync1 <= 1'b0;
      rdy_sync2 <= 1'b0;
      rdy_hist  <= 1'b0;
    end else begin
      state     <= state_nxt;
      rdy_sync1 <= MCU_RDY;
      rdy_sync2 <= rdy_sync1;
      rdy_hist  <= rdy_sync2;
      if (start) begin
        count <= 8'd0;
        grant <= hit_index;
      end else if (state == WAIT && count != 8'hFF) begin
        count <= count + 8'd1;
      end
    end
  end

  // Abort outranks a ready edge, and a ready edge outranks the timeout.
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    TIMEOUT   = 1'b0;
    INT_REQ   = 4'b0000;
    DSACK     = 2'b11;
    DSACK_OE  = 1'b0;
    case (state)
      IDLE: begin
        if (!AS20 && !DS20 && PUNT_IN && ENABLE && (HIT != 4'b0000)) begin
          start     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        INT_REQ  = 4'b0001 << grant;
        DSACK_OE = 1'b1;
        if (AS20) begin
          state_nxt = IDLE;
        end else if (rdy_edge) begin
          state_nxt = ACK;
        end else if (count == LAST_COUNT) begin
          TIMEOUT   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        DSACK    = 2'b10;
        DSACK_OE = 1'b1;
        if (AS20) state_nxt = RELEASE;
      end
      RELEASE: begin
        DSACK_OE  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
